lcd_strobe_gen: RTL
===================

Name: lcd_strobe_gen

Overview:
- Parametrised successor to the one-cycle LCD enable pulse generator.
- Detects a change on a DATA_W-bit sense bus, or accepts an explicit start. Latches the value and emits an HD44780-style E strobe with programmable setup, pulse-width and hold phases.
- Keeps data_out stable for the whole transaction and queues one pending request that arrives while busy.
- Sits between the LCD command/data sequencer and the LCD pins.

Parameters:
- DATA_W, 8, width of sense/data bus.
- SETUP_CYCLES, 2, cycles data_out is stable before E rises (>=1).
- PULSE_CYCLES, 12, cycles E is high (>=1).
- HOLD_CYCLES, 2, cycles data_out is held after E falls (>=1).
- CNT_W, $clog2(max(SETUP,PULSE,HOLD)+1), phase counter width (derived, localparam).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- sense  in  DATA_W  value to present to LCD; any change triggers a transaction
- start  in  1  forces a transaction with the current sense even if unchanged
- e  out  1  LCD enable strobe
- data_out  out  DATA_W  latched bus value, stable from SETUP through HOLD
- busy  out  1  high while state != IDLE
- done  out  1  one-cycle pulse after each transaction's final HOLD cycle
- drop_cnt  out  8  saturating count of pending requests overwritten before service

Behaviour:
- Reset: all outputs and internal registers go to 0 at the next clk edge while rst=1. This covers prev_sense, the pending flag, pend_data, the counter, state=IDLE, e, data_out, busy, done and drop_cnt. Reset mid-transaction aborts it: e=0 and busy=0 after that edge, and the pending request is discarded.
- Trigger: trig = start | (sense != prev_sense). prev_sense <= sense every non-reset cycle. Because prev_sense resets to 0, a nonzero sense after reset triggers once.
- Timing: let T be the edge that samples trig in IDLE.
  - From T: data_out <= sense, state SETUP for SETUP_CYCLES cycles.
  - Then PULSE for PULSE_CYCLES cycles, with e=1 exactly in those cycles (registered output, no glitches).
  - Then HOLD for HOLD_CYCLES cycles.
  - busy=1 for SETUP+PULSE+HOLD cycles starting after edge T.
  - done=1 for exactly one cycle, the cycle after the last HOLD cycle.
- States and transitions:
  - IDLE -> SETUP on trig.
  - SETUP -> PULSE when cnt == SETUP_CYCLES-1.
  - PULSE -> HOLD when cnt == PULSE_CYCLES-1.
  - HOLD -> IDLE when cnt == HOLD_CYCLES-1, or HOLD -> SETUP (back-to-back) when a request is pending or trig is present that cycle.
  - cnt clears on every state entry.
- Pending queue (depth 1):
  - trig while state != IDLE sets pending and pend_data <= sense; the latest value wins.
  - If pending was already set, drop_cnt increments, saturating at 255.
  - On the HOLD exit, a trig in that same cycle takes priority: data_out <= sense and pending clears. No drop_cnt increment if no older pending existed; the older pending is counted as dropped if present.
  - Otherwise data_out <= pend_data and pending clears. Back-to-back transactions have no idle gap, but done still pulses for the finished one, concurrently with busy staying high.
- Simultaneous events: start and a sense change in the same cycle give one trigger. A trig in the same cycle as rst is ignored.
- data_out changes only on transaction entry. It is never modified during SETUP, PULSE or HOLD.

Decomposition:
- Package lcd_pkg:
  - typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} strobe_state_t;
  - default timing localparams LCD_SETUP_DEF, LCD_PULSE_DEF, LCD_HOLD_DEF.
- Sub-module lcd_change_detect (DATA_W parameter, clk/rst): registers prev_sense and outputs the one-cycle trig from sense/start.

Test Plan (SETUP=2, PULSE=4, HOLD=2, DATA_W=8):
1. Single transaction:
   - Stimulus: after reset, sense 0x00->0x41 sampled at edge T.
   - Response: data_out=0x41 from T+1; busy high cycles T+1..T+8; e high cycles T+3..T+6; done high cycle T+9 only.
2. No change:
   - Stimulus: sense held at 0x41 for 50 cycles after test 1.
   - Response: e, busy and done stay 0. Then start=1 for one cycle gives a full transaction with data_out=0x41.
3. Queue while busy:
   - Stimulus: during PULSE of a 0x30 transaction, sense -> 0x31.
   - Response: second transaction starts immediately after HOLD with data_out=0x31. busy stays high continuously, done pulses once between the two, drop_cnt=0.
4. Overwrite pending:
   - Stimulus: during one transaction, sense goes 0x30 -> 0x32 -> 0x33 on separate cycles.
   - Response: next transaction carries 0x33; drop_cnt=1. Repeat 300 times: drop_cnt saturates at 255.
5. Reset mid-PULSE:
   - Stimulus: assert rst for one cycle while e=1 with a pending request.
   - Response: after that edge, e=busy=done=0, data_out=0x00, drop_cnt=0, and no transaction follows until a new trigger.
6. Trigger on last HOLD cycle:
   - Stimulus: sense changes to 0x55 exactly in the final HOLD cycle, with no prior pending.
   - Response: HOLD -> SETUP directly, data_out=0x55, drop_cnt unchanged.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and default timing for the LCD enable-strobe generator.
package lcd_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} strobe_state_t;

  localparam int LCD_SETUP_DEF = 2;
  localparam int LCD_PULSE_DEF = 12;
  localparam int LCD_HOLD_DEF  = 2;

  function automatic int lcd_max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lcd_change_detect.sv
// Registers the previous sense value and flags a trigger on change or explicit start.
module lcd_change_detect #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sense,
  input  logic              start,
  output logic              trig
);

  logic [DATA_W-1:0] prev_sense;

  always_ff @(posedge clk) begin
    if (rst) prev_sense <= '0;
    else     prev_sense <= sense;
  end

  assign trig = start | (sense != prev_sense);

endmodule

// File: rtl/lcd_strobe_gen.sv
// HD44780-style E strobe generator: latches the bus on a trigger and sequences
// SETUP / PULSE / HOLD phases, with a one-deep pending request queue.
module lcd_strobe_gen
  import lcd_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int SETUP_CYCLES = LCD_SETUP_DEF,
  parameter int PULSE_CYCLES = LCD_PULSE_DEF,
  parameter int HOLD_CYCLES  = LCD_HOLD_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sense,
  input  logic              start,
  output logic              e,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              done,
  output logic [7:0]        drop_cnt
);

  localparam int CNT_W = $clog2(lcd_max3(SETUP_CYCLES, PULSE_CYCLES, HOLD_CYCLES) + 1);

  strobe_state_t     state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic              trig;
  logic              pending;
  logic [DATA_W-1:0] pend_data;

  logic              setup_last, pulse_last, hold_exit;
  logic              e_next, busy_next, done_next;
  logic              load;
  logic [DATA_W-1:0] load_val;

  lcd_change_detect #(.DATA_W(DATA_W)) u_detect (
    .clk   (clk),
    .rst   (rst),
    .sense (sense),
    .start (start),
    .trig  (trig)
  );

  assign setup_last = (state == SETUP) && (cnt == CNT_W'(SETUP_CYCLES - 1));
  assign pulse_last = (state == PULSE) && (cnt == CNT_W'(PULSE_CYCLES - 1));
  assign hold_exit  = (state == HOLD)  && (cnt == CNT_W'(HOLD_CYCLES - 1));

  // State register; cnt restarts on every state entry, including HOLD -> SETUP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state_next != state) cnt <= '0;
      else                     cnt <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (trig)       state_next = SETUP;
      SETUP: if (setup_last) state_next = PULSE;
      PULSE: if (pulse_last) state_next = HOLD;
      HOLD:  if (hold_exit)  state_next = (trig || pending) ? SETUP : IDLE;
      default:               state_next = IDLE;
    endcase
  end

  // A live trigger at HOLD exit beats the queued value.
  always_comb begin
    e_next    = (state_next == PULSE);
    busy_next = (state_next != IDLE);
    done_next = hold_exit;
    load      = ((state == IDLE) && trig) || (hold_exit && (trig || pending));
    load_val  = ((state == IDLE) || trig) ? sense : pend_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      data_out  <= '0;
      pending   <= 1'b0;
      pend_data <= '0;
      drop_cnt  <= '0;
    end else begin
      e    <= e_next;
      busy <= busy_next;
      done <= done_next;
      if (load) data_out <= load_val;
      if (state != IDLE) begin
        if (hold_exit) begin
          pending <= 1'b0;
          if (trig && pending && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
        end else if (trig) begin
          pending   <= 1'b1;
          pend_data <= sense;
          if (pending && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
        end
      end
    end
  end

endmodule
